// File: rtl/mul_host_pkg.sv
// Shared types and default widths for the multiplier host driver.
package mul_host_pkg;

  localparam int X_WIDTH         = 2;
  localparam int Y_WIDTH         = 2;
  localparam int P_WIDTH         = 4;
  localparam int ERR_COUNT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

endpackage

// File: rtl/mul_host_timeout_ctr.sv
// Clear/enable counter with terminal-count flag; saturates at LIMIT, never wraps.
module mul_host_timeout_ctr #(
  parameter int LIMIT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != CW'(LIMIT))) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // tc flags the increment that brings the count to LIMIT.
  assign o_tc = i_en && (r_cnt == CW'(LIMIT - 1));

endmodule

// File: rtl/mul_host_driver.sv
// Host-side driver for a multiplier pin interface: request -> x/y, wait for rdy, return p/s.
// Optional MUL_HOST_CHECK_EN adds a golden product compare with resp_err / err_count.
module mul_host_driver #(
  parameter int X_WIDTH = mul_host_pkg::X_WIDTH,
  parameter int Y_WIDTH = mul_host_pkg::Y_WIDTH,
  parameter int P_WIDTH = mul_host_pkg::P_WIDTH,
  parameter int TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [X_WIDTH-1:0] req_x,
  input  logic [Y_WIDTH-1:0] req_y,
  output logic [X_WIDTH-1:0] dut_x,
  output logic [Y_WIDTH-1:0] dut_y,
  input  logic [P_WIDTH-1:0] dut_p,
  input  logic               dut_s,
  input  logic               dut_rdy,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [P_WIDTH-1:0] resp_p,
  output logic               resp_s,
`ifdef MUL_HOST_CHECK_EN
  output logic                                     resp_err,
  output logic [mul_host_pkg::ERR_COUNT_WIDTH-1:0] err_count,
`endif
  output logic               resp_timeout
);

  import mul_host_pkg::*;

  state_t             r_state, w_next;
  logic [X_WIDTH-1:0] r_dut_x;
  logic [Y_WIDTH-1:0] r_dut_y;
  logic [P_WIDTH-1:0] r_resp_p;
  logic               r_resp_s;
  logic               r_resp_to;
  logic               w_accept;
  logic               w_ctr_en;
  logic               w_tc;
  logic               w_timeout;

  assign w_accept  = (r_state == ST_IDLE) && req_valid;
  assign w_ctr_en  = (r_state == ST_WAIT) && !dut_rdy;
  // dut_rdy has priority over the terminal count on the same cycle.
  assign w_timeout = w_ctr_en && w_tc;

  mul_host_timeout_ctr #(.LIMIT(TIMEOUT)) u_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (w_accept),
    .i_en  (w_ctr_en),
    .o_tc  (w_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (req_valid)              w_next = ST_SETTLE;
      ST_SETTLE:                             w_next = ST_WAIT;
      ST_WAIT:   if (dut_rdy || w_timeout)   w_next = ST_RESP;
      ST_RESP:   if (resp_ready)             w_next = ST_IDLE;
      default:                               w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dut_x   <= '0;
      r_dut_y   <= '0;
      r_resp_p  <= '0;
      r_resp_s  <= 1'b0;
      r_resp_to <= 1'b0;
    end else begin
      if (w_accept) begin
        r_dut_x <= req_x;
        r_dut_y <= req_y;
      end
      if ((r_state == ST_WAIT) && dut_rdy) begin
        r_resp_p  <= dut_p;
        r_resp_s  <= dut_s;
        r_resp_to <= 1'b0;
      end else if (w_timeout) begin
        r_resp_p  <= '0;
        r_resp_s  <= 1'b0;
        r_resp_to <= 1'b1;
      end
    end
  end

`ifdef MUL_HOST_CHECK_EN
  logic [P_WIDTH-1:0]         w_golden;
  logic                       r_resp_err;
  logic [ERR_COUNT_WIDTH-1:0] r_err_cnt;

  assign w_golden = P_WIDTH'(r_dut_x) * P_WIDTH'(r_dut_y);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_resp_err <= 1'b0;
      r_err_cnt  <= '0;
    end else begin
      if ((r_state == ST_WAIT) && dut_rdy) r_resp_err <= (dut_p != w_golden);
      else if (w_timeout)                  r_resp_err <= 1'b1;
      if ((r_state == ST_RESP) && resp_ready && r_resp_err && (r_err_cnt != '1))
        r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

  assign resp_err  = r_resp_err;
  assign err_count = r_err_cnt;
`endif

  assign req_ready    = (r_state == ST_IDLE);
  assign resp_valid   = (r_state == ST_RESP);
  assign dut_x        = r_dut_x;
  assign dut_y        = r_dut_y;
  assign resp_p       = r_resp_p;
  assign resp_s       = r_resp_s;
  assign resp_timeout = r_resp_to;

endmodule

// File: tb/tb_mul_host_driver.sv
// Randomized self-checking bench for mul_host_driver against a latency/result reference model.
module tb_mul_host_driver;

  localparam int XW = 2, YW = 2, PW = 4, TO = 15;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid, req_ready;
  logic [XW-1:0] req_x, dut_x;
  logic [YW-1:0] req_y, dut_y;
  logic [PW-1:0] dut_p, resp_p;
  logic          dut_s, dut_rdy;
  logic          resp_valid, resp_ready, resp_s, resp_timeout;
`ifdef MUL_HOST_CHECK_EN
  logic          resp_err;
  logic [7:0]    err_count;
  int            m_err_cnt = 0;
`endif

  int n_chk = 0, n_pass = 0;
  int age = 1000, rdy_delay = 1000;
  bit s_bit = 1'b0, fault_en = 1'b0;

  mul_host_driver #(.X_WIDTH(XW), .Y_WIDTH(YW), .P_WIDTH(PW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_x(req_x), .req_y(req_y),
    .dut_x(dut_x), .dut_y(dut_y), .dut_p(dut_p), .dut_s(dut_s), .dut_rdy(dut_rdy),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_p(resp_p), .resp_s(resp_s),
`ifdef MUL_HOST_CHECK_EN
    .resp_err(resp_err), .err_count(err_count),
`endif
    .resp_timeout(resp_timeout)
  );

  always #5 clk = ~clk;

  // Multiplier model: result valid rdy_delay cycles after the operands change.
  always @(posedge clk) begin
    if (req_valid && req_ready) age <= 0;
    else if (age < 1000)        age <= age + 1;
  end
  assign dut_p   = fault_en ? PW'(5) : PW'(dut_x) * PW'(dut_y);
  assign dut_s   = s_bit;
  assign dut_rdy = (age >= rdy_delay);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic accept(input logic [XW-1:0] x, input logic [YW-1:0] y);
    @(negedge clk);
    chk("req_ready_idle", req_ready, 1);
    req_valid = 1'b1; req_x = x; req_y = y;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic do_op(input int x, input int y, input int d, input bit s,
                       input bit fault, input int hold);
    int e, exp_lat, exp_p, cyc;
    bit exp_to, exp_s, got, exp_err;
    rdy_delay = d; s_bit = s; fault_en = fault;
    accept(XW'(x), YW'(y));
    // First rdy sample is two edges after accept; the last one is edge TO+1.
    e = (d + 1 > 2) ? d + 1 : 2;
    if (e <= TO + 1) begin
      exp_lat = e + 1; exp_to = 0; exp_p = fault ? 5 : x * y; exp_s = s;
    end else begin
      exp_lat = TO + 2; exp_to = 1; exp_p = 0; exp_s = 0;
    end
    exp_err = exp_to || (exp_p != x * y);
    cyc = 0; got = 0;
    while (cyc < 40 && !got) begin
      @(negedge clk);
      cyc++;
      if (resp_valid) got = 1;
      else if (req_ready) chk("req_ready_busy", req_ready, 0);
    end
    chk("resp_valid_seen", got, 1);
    chk("latency", cyc, exp_lat);
    chk("resp_p", resp_p, exp_p);
    chk("resp_s", resp_s, exp_s);
    chk("resp_timeout", resp_timeout, exp_to);
    chk("dut_x", dut_x, x);
    chk("dut_y", dut_y, y);
`ifdef MUL_HOST_CHECK_EN
    chk("resp_err", resp_err, exp_err);
    chk("err_count", err_count, m_err_cnt);
`endif
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", resp_valid, 1);
      chk("hold_p", resp_p, exp_p);
      chk("hold_req_ready", req_ready, 0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("idle_after_resp", req_ready, 1);
    chk("valid_dropped", resp_valid, 0);
`ifdef MUL_HOST_CHECK_EN
    if (exp_err && m_err_cnt < 255) m_err_cnt++;
    chk("err_count_after", err_count, m_err_cnt);
`endif
  endtask

  initial begin
    bit seen;
    rst_n = 1'b0; req_valid = 1'b0; req_x = '0; req_y = '0; resp_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_dut_xy", {dut_x, dut_y}, 0);
    chk("rst_resp", {resp_p, resp_s, resp_timeout}, 0);
    rst_n = 1'b1;

    do_op(3, 3, 1, 0, 0, 0);           // basic
    do_op(2, 3, 1, 1, 0, 5);           // backpressure
    do_op(1, 2, 1000, 1, 0, 1);        // timeout
    do_op(3, 2, TO, 1, 0, 0);          // tie: rdy on the terminal cycle
    do_op(2, 2, TO + 1, 0, 0, 0);      // one cycle too late
    do_op(3, 1, 0, 1, 0, 0);           // stale rdy during SETTLE
`ifdef MUL_HOST_CHECK_EN
    do_op(2, 2, 1, 0, 1, 0);           // faulty product
    do_op(1, 3, 1, 0, 0, 0);
`endif
    for (int k = 0; k < 30; k++)
      do_op($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 18),
            1'($urandom_range(0, 1)), 1'b0, $urandom_range(0, 3));

    // Reset in the middle of WAIT drops the operation.
    rdy_delay = 1000;
    accept(2'd3, 2'd2);
    repeat (4) @(negedge clk);
    rst_n = 1'b0; #1;
    chk("midrst_req_ready", req_ready, 1);
    chk("midrst_resp_valid", resp_valid, 0);
    chk("midrst_dut_xy", {dut_x, dut_y}, 0);
    chk("midrst_resp", {resp_p, resp_s, resp_timeout}, 0);
`ifdef MUL_HOST_CHECK_EN
    m_err_cnt = 0;
    chk("midrst_err", {resp_err, err_count}, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (25) begin
      @(negedge clk);
      if (resp_valid) seen = 1;
    end
    chk("no_resp_after_rst", seen, 0);
    do_op(1, 1, 2, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mul_host_driver.md
# mul_host_driver

On-chip host-side driver for the small multiplier cores' pin-level interface. It accepts operand pairs over a valid/ready request port and drives the multiplier's `x`/`y` inputs. It then waits for the multiplier's ready flag, captures product and sign, and returns them on a valid/ready response port. It sits between a test sequencer or scan controller and a multiplier top (e.g. the 2x2 unsigned core), and is the requesting end of the same `x`/`y` -> `p`/`s`/`rdy` interface.

## Interface

Parameters:
- `X_WIDTH`, default 2: operand x width.
- `Y_WIDTH`, default 2: operand y width.
- `P_WIDTH`, default 4: product width; must be at least `X_WIDTH+Y_WIDTH`.
- `TIMEOUT`, default 15: number of WAIT cycles before giving up; range 1..255.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `req_valid`  in  1  operand pair offered.
- `req_ready`  out  1  driver can accept a request.
- `req_x`  in  `X_WIDTH`  operand x.
- `req_y`  in  `Y_WIDTH`  operand y.
- `dut_x`  out  `X_WIDTH`  registered x to the multiplier.
- `dut_y`  out  `Y_WIDTH`  registered y to the multiplier.
- `dut_p`  in  `P_WIDTH`  product from the multiplier.
- `dut_s`  in  1  sign from the multiplier.
- `dut_rdy`  in  1  multiplier result-valid flag.
- `resp_valid`  out  1  response available.
- `resp_ready`  in  1  consumer accepts the response.
- `resp_p`  out  `P_WIDTH`  captured product.
- `resp_s`  out  1  captured sign.
- `resp_timeout`  out  1  `dut_rdy` never asserted within `TIMEOUT` cycles.

## Operation

- FSM states: IDLE, SETTLE, WAIT, RESP.
- **IDLE:** `req_ready`=1. On `req_valid && req_ready`, register `req_x`/`req_y` into `dut_x`/`dut_y`, clear the timeout counter, and go to SETTLE.
- **SETTLE:** exactly one cycle. `dut_rdy` is ignored because it may be stale from the previous operand. Go to WAIT.
- **WAIT:**
  - If `dut_rdy`=1, capture `dut_p` -> `resp_p` and `dut_s` -> `resp_s`, clear `resp_timeout`, and go to RESP.
  - Otherwise increment the counter. When the counter reaches `TIMEOUT`, set `resp_p`=0, `resp_s`=0, `resp_timeout`=1, and go to RESP.
  - If `dut_rdy` rises on the same cycle the counter reaches `TIMEOUT`, `dut_rdy` wins and the operation completes normally.
- **RESP:** `resp_valid`=1. `resp_p`, `resp_s` and `resp_timeout` are held stable until `resp_ready`=1. Then return to IDLE.
- `dut_x`/`dut_y` hold their value from accept until the next accept; they are not cleared on return to IDLE.
- `req_ready` is 1 only in IDLE. There is no request/response overlap, so there is at most one operation in flight.
- Timeout counter: `$clog2(TIMEOUT+1)` bits, never wraps.
- Reset (asynchronous, any state): state=IDLE. `req_ready`=1. `dut_x`, `dut_y`, `resp_p`, `resp_s`, `resp_timeout`, `resp_valid` and the counter all reset to 0. An in-flight operation is dropped with no response.

## Timing

- Accept at edge 0 -> `dut_x`/`dut_y` valid after edge 0 -> SETTLE cycle -> first `dut_rdy` sample at edge 2.
- Minimum latency, accept edge to `resp_valid` high: 3 cycles, when `dut_rdy` is already 1 at edge 2.
- Timeout response: `resp_valid` high `TIMEOUT+2` cycles after the accept edge.
- Back-to-back throughput: one operation per 4 cycles minimum (accept, SETTLE, WAIT, RESP with `resp_ready`=1).
- `dut_p`, `dut_s` and `dut_rdy` are treated as synchronous to `clk`. No synchronizers.

## Configuration

- Macro `MUL_HOST_CHECK_EN`.
- **Defined:**
  - Adds output `resp_err` (1 bit) and output `err_count` (8 bits, saturating at 255).
  - On a normal capture, the expected value is the unsigned product `dut_x*dut_y` zero-extended to `P_WIDTH`. `resp_err` is 1 if `resp_p` differs from it.
  - On timeout, `resp_err`=1.
  - `err_count` increments on each response handshake with `resp_err`=1.
  - Both reset to 0.
- **Undefined:** neither port exists and no compare logic is built.

## Structure

- Shared package holds:
  - The FSM state enum (IDLE, SETTLE, WAIT, RESP).
  - Default width constants `X_WIDTH`/`Y_WIDTH`/`P_WIDTH`, matching the global width definitions.
  - `ERR_COUNT_WIDTH`=8.
- One natural sub-module: `mul_host_timeout_ctr`, a clear/enable/terminal-count counter.
- The golden compare stays inline under the macro.

## Test plan

- **Basic:** x=3, y=3; model `dut_rdy` rising 1 cycle after `dut_x` changes -> `resp_p`=9, `resp_s`=0, `resp_timeout`=0, `resp_valid` at cycle 3.
- **Backpressure:** x=2, y=3; hold `resp_ready`=0 for 5 cycles -> `resp_p`=6 stable, `req_ready`=0 throughout; IDLE one cycle after `resp_ready`=1.
- **Timeout:** `dut_rdy` tied 0, `TIMEOUT`=15 -> `resp_timeout`=1, `resp_p`=0, `resp_valid` at cycle 17. With `MUL_HOST_CHECK_EN`, `resp_err`=1 and `err_count`=1.
- **Tie:** `dut_rdy` asserts on the exact cycle the counter reaches `TIMEOUT` -> normal capture, `resp_timeout`=0.
- **Reset mid-op:** assert `rst_n`=0 during WAIT -> all outputs 0 immediately, `req_ready`=1, no `resp_valid` afterward.
- **Check:** with `MUL_HOST_CHECK_EN`, faulty model returns `dut_p`=5 for x=2, y=2 -> `resp_err`=1, `err_count` 0->1. A following x=1, y=3 returning 3 -> `resp_err`=0, `err_count` stays 1.
